// File: rtl/saida_somador_pkg.sv
// saida_somador_pkg: shared ALU types -- flag bit indices, buffer state enum and buffered entry
package saida_somador_pkg;
  localparam int SUM_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [SUM_W-1:0] s;
    logic [3:0]       flags;
  } entry_t;
endpackage

// File: rtl/saida_somador_if.sv
// saida_somador_if: adder-result input handshake, buffered output handshake and carry counter access
//   slave  = output stage view (takes in_*, out_ready, clr_count; drives in_ready, out_*, carry_count)
//   master = producer/consumer view (the opposite directions)
interface saida_somador_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic             in_cout;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] carry_count;
  logic             clr_count;
  modport slave (
    input  in_valid, in_s, in_cout, in_a_msb, in_b_msb, out_ready, clr_count,
    output in_ready, out_valid, out_s, out_flags, carry_count
  );
  modport master (
    output in_valid, in_s, in_cout, in_a_msb, in_b_msb, out_ready, clr_count,
    input  in_ready, out_valid, out_s, out_flags, carry_count
  );
endinterface

// File: rtl/saida_somador_flags.sv
// flags_somador: combinational {N,Z,C,V} from sum, carry-out and operand MSBs (ports: s, cout, a_msb, b_msb -> flags)
module flags_somador
  import saida_somador_pkg::*;
#(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic [3:0]       flags
);
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = s[WIDTH-1];
    flags[FLAG_Z] = (s == '0);
    flags[FLAG_C] = cout;
    flags[FLAG_V] = (a_msb == b_msb) && (s[WIDTH-1] != a_msb);
  end
endmodule

// File: rtl/saida_somador.sv
// saida_somador: 2-entry skid-buffered adder output stage with N/Z/C/V flags and saturating carry counter
//   ports: clk, rst_n (async active-low), bus (saida_somador_if.slave)
module saida_somador
  import saida_somador_pkg::*;
#(parameter int WIDTH = SUM_W, parameter int CNT_W = 8) (
  input logic            clk,
  input logic            rst_n,
  saida_somador_if.slave bus
);
  state_t           state, state_nxt;
  entry_t           main_q, skid_q, in_entry;
  logic [3:0]       in_flags;
  logic [CNT_W-1:0] cnt;
  logic             in_fire, out_fire, load_main, load_skid, pop_skid;
  flags_somador #(.WIDTH(WIDTH)) u_flags (
    .s(bus.in_s), .cout(bus.in_cout), .a_msb(bus.in_a_msb), .b_msb(bus.in_b_msb), .flags(in_flags)
  );
  assign in_entry      = '{s: bus.in_s, flags: in_flags};
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_s     = main_q.s;
  assign bus.out_flags = main_q.flags;
  assign bus.carry_count = cnt;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_fire;
        state_nxt = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_fire && out_fire;
        load_skid = in_fire && !out_fire;
        state_nxt = (in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE;
      end
      FULL: begin
        pop_skid  = out_fire;
        state_nxt = out_fire ? ONE : FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= load_main ? in_entry : pop_skid ? skid_q : main_q;
      skid_q <= load_skid ? in_entry : skid_q;
      cnt    <= bus.clr_count ? '0 : (in_fire && bus.in_cout && cnt != '1) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: tb/tb_saida_somador.sv
// tb_saida_somador: directed-vector self-checking bench for saida_somador (CNT_W=2)
module tb_saida_somador;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  saida_somador_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  saida_somador #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [3:0] s, input logic c, input logic a, input logic b);
    bus.in_valid = v;
    bus.in_s     = s;
    bus.in_cout  = c;
    bus.in_a_msb = a;
    bus.in_b_msb = b;
  endtask
  initial begin
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.clr_count = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_count", 32'(bus.carry_count), 0);
    chk("rst_out_s", 32'(bus.out_s), 0);
    chk("rst_flags", 32'(bus.out_flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", 32'(bus.out_valid), 0);
    // flag cases: 1000+1000 style overflow to zero with carry, then 0xxx+0xxx overflowing to negative
    bus.out_ready = 1'b1;
    drive(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    chk("f1_valid", 32'(bus.out_valid), 1);
    chk("f1_s", 32'(bus.out_s), 0);
    chk("f1_flags", 32'(bus.out_flags), 32'b0111);
    chk("f1_count", 32'(bus.carry_count), 1);
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    chk("f2_s", 32'(bus.out_s), 4'b1000);
    chk("f2_flags", 32'(bus.out_flags), 32'b1001);
    chk("f2_count", 32'(bus.carry_count), 1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("f_drain", 32'(bus.out_valid), 0);
    // backpressure: A, B fill the buffer, C stalls until space frees
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_a_s", 32'(bus.out_s), 3);
    chk("bp_a_rdy", 32'(bus.in_ready), 1);
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_full_rdy", 32'(bus.in_ready), 0);
    chk("bp_b_s", 32'(bus.out_s), 3);
    drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_stall_s", 32'(bus.out_s), 3);
    chk("bp_stall_flags", 32'(bus.out_flags), 32'b0000);
    chk("bp_stall_valid", 32'(bus.out_valid), 1);
    chk("bp_stall_rdy", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_out_b", 32'(bus.out_s), 5);
    chk("bp_rdy_again", 32'(bus.in_ready), 1);
    step();
    chk("bp_out_c", 32'(bus.out_s), 7);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_drain", 32'(bus.out_valid), 0);
    // streaming: one result per cycle through state ONE
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b0);
      step();
      chk("st_valid", 32'(bus.out_valid), 1);
      chk("st_s", 32'(bus.out_s), 32'(i + 1));
      chk("st_rdy", 32'(bus.in_ready), 1);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("st_drain", 32'(bus.out_valid), 0);
    // counter saturation at 3 starting from 1
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
      step();
      chk("cnt_sat", 32'(bus.carry_count), (i + 2 > 3) ? 3 : i + 2);
    end
    bus.clr_count = 1'b1;
    step();
    chk("cnt_clr_wins", 32'(bus.carry_count), 0);
    bus.clr_count = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("cnt_hold", 32'(bus.carry_count), 0);
    // asynchronous reset while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    step();
    chk("rf_full", 32'(bus.in_ready), 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf_async_valid", 32'(bus.out_valid), 0);
    chk("rf_async_rdy", 32'(bus.in_ready), 1);
    chk("rf_async_s", 32'(bus.out_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("rf_discard", 32'(bus.out_valid), 0);
    drive(1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    step();
    chk("rf_new_s", 32'(bus.out_s), 4'hC);
    chk("rf_new_flags", 32'(bus.out_flags), 32'b1000);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rf_new_drain", 32'(bus.out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
